// File: rtl/mul_12.sv
// 3-stage pipelined multiplier for the 12-bit float format {sgn, exp[4:0], man[5:0]}, bias 15.
// Truncating normalisation, flush-to-zero on underflow, saturation on overflow.
module mul_12 #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 6,
    parameter int BIAS  = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     valid_i,
    input  logic [EXP_W+MAN_W:0]     data_1_i,
    input  logic [EXP_W+MAN_W:0]     data_2_i,
    output logic                     valid_o,
    output logic [EXP_W+MAN_W:0]     data_prod_o
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 1;
    localparam int PW = 2 * MW;
    localparam int SW = EXP_W + 1;
    localparam int EW = EXP_W + 3;
    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);

    // valid shift register runs alongside the data stages
    logic [2:0]       vld_q;

    logic             sgn1_q, zero1_q;
    logic [SW-1:0]    esum1_q;
    logic [MW-1:0]    ma1_q, mb1_q;

    logic             sgn2_q, zero2_q;
    logic [SW-1:0]    esum2_q;
    logic [PW-1:0]    p2_q;

    logic [W-1:0]     prod3_q;

    logic             sgn1_d, zero1_d;
    logic [SW-1:0]    esum1_d;
    logic [MW-1:0]    ma1_d, mb1_d;
    logic [PW-1:0]    p2_d;
    logic [W-1:0]     prod3_d;

    logic signed [EW-1:0] e_s;
    logic [MAN_W-1:0]     man_n;

    always_comb begin
        sgn1_d  = data_1_i[W-1] ^ data_2_i[W-1];
        zero1_d = (data_1_i[W-2:0] == '0) | (data_2_i[W-2:0] == '0);
        esum1_d = {1'b0, data_1_i[W-2:MAN_W]} + {1'b0, data_2_i[W-2:MAN_W]};
        ma1_d   = {1'b1, data_1_i[MAN_W-1:0]};
        mb1_d   = {1'b1, data_2_i[MAN_W-1:0]};
        p2_d    = {{MW{1'b0}}, ma1_q} * {{MW{1'b0}}, mb1_q};
    end

    // p2_q[PW-1:PW-2] is never 00, so a single-bit shift normalises
    always_comb begin
        e_s     = $signed({2'b00, esum2_q}) - BIAS_S
                + $signed({{(EW-1){1'b0}}, p2_q[PW-1]});
        man_n   = p2_q[PW-1] ? p2_q[PW-2 -: MAN_W] : p2_q[PW-3 -: MAN_W];
        prod3_d = '0;
        if (zero2_q || e_s < 0 || (e_s == 0 && man_n == '0)) begin
            prod3_d = '0;
        end else if (e_s > EMAX_S) begin
            prod3_d = {sgn2_q, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
        end else begin
            prod3_d = {sgn2_q, e_s[EXP_W-1:0], man_n};
        end
    end

    logic unused_p_lo;
    assign unused_p_lo = ^p2_q[PW-MW-2:0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q   <= '0;
            sgn1_q  <= 1'b0;
            zero1_q <= 1'b0;
            esum1_q <= '0;
            ma1_q   <= '0;
            mb1_q   <= '0;
            sgn2_q  <= 1'b0;
            zero2_q <= 1'b0;
            esum2_q <= '0;
            p2_q    <= '0;
            prod3_q <= '0;
        end else begin
            vld_q   <= {vld_q[1:0], valid_i};
            sgn1_q  <= sgn1_d;
            zero1_q <= zero1_d;
            esum1_q <= esum1_d;
            ma1_q   <= ma1_d;
            mb1_q   <= mb1_d;
            sgn2_q  <= sgn1_q;
            zero2_q <= zero1_q;
            esum2_q <= esum1_q;
            p2_q    <= p2_d;
            prod3_q <= prod3_d;
        end
    end

    assign valid_o     = vld_q[2];
    assign data_prod_o = prod3_q;

endmodule
